// File: rtl/branch_seq_ctrl.sv
// branch_seq_ctrl: sequences jump resolution between decode, the flag
// register and the jump-condition evaluator. Stalls the front end, waits
// for outstanding flag writes, wakes the evaluator for one cycle and turns a
// taken decision into a PC redirect plus an IF/ID flush window. Keeps
// saturating taken/not-taken statistics.
module branch_seq_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int WAIT_LIMIT   = 15,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_valid,
    input  logic [3:0]        br_op,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              flags_pending,
    input  logic              jmp,
    output logic              jmp_wake,
    output logic [3:0]        jmp_op,
    output logic              stall,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush_if,
    output logic              flush_id,
    output logic              illegal_op,
    output logic              wait_timeout,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  nottaken_cnt
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FLAGS = 2'd1,
        S_RESOLVE    = 2'd2,
        S_FLUSH      = 2'd3
    } state_t;

    // Last index of each counted window (counters start at 0 on entry)
    localparam logic [7:0]       LP_WAIT_LAST  = 8'(WAIT_LIMIT - 1);
    localparam logic [3:0]       LP_FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_CNT_MAX    = {CNT_W{1'b1}};

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_wait_cnt;
    logic [3:0]        r_flush_cnt;
    logic [3:0]        r_jmp_op;
    logic [ADDR_W-1:0] r_target;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_taken_cnt;
    logic [CNT_W-1:0]  r_nottaken_cnt;
    logic              w_latch;
    logic              w_timeout;
    logic              w_resolve;
    logic              w_flush_last;

    assign w_resolve    = (r_state == S_RESOLVE);
    assign w_flush_last = (r_flush_cnt == LP_FLUSH_LAST);

    // State register; async reset aborts any in-flight redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode, branch capture strobe and timeout detection
    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (br_valid) begin
                    w_latch = 1'b1;
                    w_next  = flags_pending ? S_WAIT_FLAGS : S_RESOLVE;
                end
            end
            S_WAIT_FLAGS: begin
                if (!flags_pending) begin
                    w_next = S_RESOLVE;
                end else if (r_wait_cnt == LP_WAIT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                w_next = jmp ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: begin
                if (w_flush_last) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Window counters: held at zero outside their state so entry starts at 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt  <= 8'd0;
            r_flush_cnt <= 4'd0;
        end else begin
            r_wait_cnt  <= (r_state == S_WAIT_FLAGS) ? r_wait_cnt + 8'd1 : 8'd0;
            r_flush_cnt <= (r_state == S_FLUSH) ? r_flush_cnt + 4'd1 : 4'd0;
        end
    end

    // Capture condition code and target when a jump is accepted in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_jmp_op <= 4'd0;
            r_target <= '0;
        end else if (w_latch) begin
            r_jmp_op <= br_op;
            r_target <= br_target;
        end
    end

    // Illegal-code pulse in the cycle following RESOLVE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_resolve && (r_jmp_op >= 4'd11);
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_taken_cnt    <= '0;
            r_nottaken_cnt <= '0;
        end else if (cnt_clear) begin
            r_taken_cnt    <= '0;
            r_nottaken_cnt <= '0;
        end else if (w_resolve) begin
            if (jmp && (r_taken_cnt != LP_CNT_MAX)) begin
                r_taken_cnt <= r_taken_cnt + 1'b1;
            end
            if (!jmp && (r_nottaken_cnt != LP_CNT_MAX)) begin
                r_nottaken_cnt <= r_nottaken_cnt + 1'b1;
            end
        end
    end

    assign jmp_wake     = w_resolve;
    assign jmp_op       = r_jmp_op;
    assign stall        = (r_state != S_IDLE) || br_valid;
    assign pc_load      = (r_state == S_FLUSH) && (r_flush_cnt == 4'd0);
    assign pc_target    = r_target;
    assign flush_if     = (r_state == S_FLUSH);
    assign flush_id     = (r_state == S_FLUSH);
    assign illegal_op   = r_illegal;
    assign wait_timeout = w_timeout;
    assign taken_cnt    = r_taken_cnt;
    assign nottaken_cnt = r_nottaken_cnt;

endmodule

// File: doc/branch_seq_ctrl.md
Name: branch_seq_ctrl

Overview:
- Sequences conditional and unconditional jumps between the decode stage, the flag register and the jump-condition evaluator.
- On a decoded jump it stalls fetch/decode, waits until no in-flight instruction still owes a flag update, then pulses the evaluator's wake input for one cycle and samples its decision.
- A taken decision drives the PC redirect and an IF/ID flush window.
- Also keeps saturating taken/not-taken statistics for the testbench and debug.

Parameters:
ADDR_W, 32, width of PC / branch target
FLUSH_CYCLES, 2, cycles flush_if/flush_id stay high after a taken jump (range 1..15)
WAIT_LIMIT, 15, max cycles in WAIT_FLAGS before forced resolve (range 1..255)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
br_valid  in  1  decode holds a jump instruction
br_op  in  4  jump condition code (0..10 defined, 11..15 illegal)
br_target  in  ADDR_W  jump destination address
flags_pending  in  1  an instruction in EX/MEM will still write carry/sign/zero
jmp  in  1  decision from the condition evaluator, valid combinationally while jmp_wake=1
jmp_wake  out  1  evaluator wake, high only in RESOLVE
jmp_op  out  4  latched condition code presented to the evaluator
stall  out  1  freeze PC and IF/ID register
pc_load  out  1  one-cycle PC redirect strobe
pc_target  out  ADDR_W  redirect address, valid when pc_load=1
flush_if  out  1  squash the IF/ID instruction
flush_id  out  1  squash the ID/EX instruction
illegal_op  out  1  one-cycle pulse when br_op >= 11 is resolved
wait_timeout  out  1  one-cycle pulse when WAIT_LIMIT expires
cnt_clear  in  1  synchronous clear of both counters
taken_cnt  out  CNT_W  taken-jump count, saturating
nottaken_cnt  out  CNT_W  not-taken count, saturating

Behaviour:

Reset:
- rst high (asynchronous) puts the FSM in IDLE.
- All outputs go to 0, including counters, jmp_op and pc_target.
- Reset in any state, including mid-FLUSH, drops pc_load, flush_* and jmp_wake immediately; no redirect is issued after reset.

States: IDLE, WAIT_FLAGS, RESOLVE, FLUSH.

IDLE:
- br_valid=1 latches br_op into jmp_op and br_target into the internal target register.
- Next state is WAIT_FLAGS if flags_pending=1, else RESOLVE.
- br_valid is ignored in all other states; decode holds it while stalled.

WAIT_FLAGS:
- Wait counter is cleared on entry and increments every cycle.
- When flags_pending=0, go to RESOLVE.
- When the counter reaches WAIT_LIMIT with flags_pending still 1, pulse wait_timeout and go to RESOLVE anyway.

RESOLVE:
- Exactly one cycle; jmp_wake=1 only here, registered from the state.
- jmp is sampled at the end of this cycle.
- jmp=1: go to FLUSH; taken_cnt +1.
- jmp=0: go to IDLE; nottaken_cnt +1.
- If jmp_op >= 11, pulse illegal_op in the next cycle. The decision follows jmp regardless; the evaluator returns 0 for these codes.

FLUSH:
- Lasts FLUSH_CYCLES cycles.
- pc_load=1 and pc_target=latched target in the first FLUSH cycle only.
- flush_if=flush_id=1 on every FLUSH cycle.
- After the last FLUSH cycle, go to IDLE.

Stall:
- Combinational: br_valid in IDLE, OR state is WAIT_FLAGS or RESOLVE, OR state is FLUSH.
- Deasserts the cycle after the final RESOLVE (not taken) or final FLUSH cycle.

Latency:
- Minimum taken path: br_valid at cycle N → RESOLVE at N+1 → pc_load at N+2.
- Minimum not-taken path: stall released at N+2.

Back-to-back branches:
- IDLE re-samples br_valid in the cycle after returning.
- jmp_wake is therefore low for at least one cycle between wakes; the evaluator is edge-sensitive on wake.

Counters:
- Saturate at 2^CNT_W-1.
- cnt_clear takes priority over an increment in the same cycle.

Test Plan:
- Unconditional, no pending flags: br_op=10, br_target=0x0000_0040, flags_pending=0 at cycle 0 → jmp_wake high cycle 1; pc_load=1 with pc_target=0x40 cycle 2; flush_* high cycles 2–3; stall low cycle 4; taken_cnt=1.
- Not taken: br_op=0, evaluator jmp=0 → jmp_wake cycle 1; no pc_load, no flush; stall low cycle 2; nottaken_cnt=1.
- Flag wait: flags_pending=1 for 3 cycles after br_valid → jmp_wake exactly 4 cycles after br_valid; no wait_timeout.
- Timeout and illegal op: flags_pending stuck at 1, WAIT_LIMIT=15, br_op=12 → wait_timeout pulse, then RESOLVE; illegal_op pulse one cycle after RESOLVE; jmp=0, no redirect.
- Reset in flight: rst asserted mid-cycle during the first FLUSH cycle → pc_load, flush_* and stall drop asynchronously; counters=0; a fresh branch afterwards resolves normally.
- Back-to-back and saturation: two branches with br_valid held → jmp_wake pulses separated by a low cycle; preload taken_cnt to 0xFFFF, take a branch → stays 0xFFFF; cnt_clear together with a taken branch → taken_cnt=0.
